// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter.
package apb_arb_pkg;

    // Arbiter FSM states: one transfer walks IDLE -> SETUP -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arbState_t;

    localparam int          NUM_MASTERS      = 2;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

    // Round-robin pick between two requesters: on a tie the master that
    // was not granted last wins; otherwise the single requester wins.
    function automatic logic pickWinner(input logic req0,
                                        input logic req1,
                                        input logic lastGrant);
        if (req0 && req1) begin
            return ~lastGrant;
        end else if (req1) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles of the current transfer; saturates at TIMEOUT.
module apb_timeout_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic pCLK,
    input  logic pRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] countReg;

    // Clear has priority; holding at LIMIT keeps expired stable if the
    // FSM ever lingers for an extra cycle.
    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (enable && (countReg != LIMIT)) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign expired = (countReg == LIMIT);

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-master APB arbiter: round-robin grant, regenerated SETUP/ACCESS
// per transfer, and a watchdog that errors out hung accesses.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int             DW       = 32,
    parameter int             AW       = 32,
    parameter int             TIMEOUT  = 256,
    parameter logic [DW-1:0]  ERR_DATA = DW'(DEFAULT_ERR_DATA)
) (
    input  logic          pCLK,
    input  logic          pRESETn,

    input  logic [AW-1:0] m0_pADDR,
    input  logic [DW-1:0] m0_pWDATA,
    input  logic          m0_pSELx,
    input  logic          m0_pENABLE,
    input  logic          m0_pWRITE,
    output logic [DW-1:0] m0_pRDATA,
    output logic          m0_pREADY,
    output logic          m0_pSLVERR,

    input  logic [AW-1:0] m1_pADDR,
    input  logic [DW-1:0] m1_pWDATA,
    input  logic          m1_pSELx,
    input  logic          m1_pENABLE,
    input  logic          m1_pWRITE,
    output logic [DW-1:0] m1_pRDATA,
    output logic          m1_pREADY,
    output logic          m1_pSLVERR,

    output logic [AW-1:0] pADDR,
    output logic [DW-1:0] pWDATA,
    output logic          pSELx,
    output logic          pENABLE,
    output logic          pWRITE,
    input  logic [DW-1:0] pRDATA,
    input  logic          pREADY,
    input  logic          pSLVERR,

    output logic          to_pulse,
    output logic [AW-1:0] to_addr
);

    // Per-master views so the datapath can be indexed by grant.
    logic [AW-1:0] mAddr   [NUM_MASTERS];
    logic [DW-1:0] mWdata  [NUM_MASTERS];
    logic          mWrite  [NUM_MASTERS];
    logic          mReq    [NUM_MASTERS];
    logic [DW-1:0] rdataReg[NUM_MASTERS];
    logic          mReady  [NUM_MASTERS];
    logic          mSlvErr [NUM_MASTERS];

    assign mAddr[0]  = m0_pADDR;
    assign mAddr[1]  = m1_pADDR;
    assign mWdata[0] = m0_pWDATA;
    assign mWdata[1] = m1_pWDATA;
    assign mWrite[0] = m0_pWRITE;
    assign mWrite[1] = m1_pWRITE;
    assign mReq[0]   = m0_pSELx;
    assign mReq[1]   = m1_pSELx;

    // Master ENABLE carries no information for arbitration: a request is
    // its SEL, and the transfer is regenerated downstream anyway.
    logic unusedEnable;
    assign unusedEnable = m0_pENABLE ^ m1_pENABLE;

    arbState_t     stateReg;
    arbState_t     stateNext;
    logic [AW-1:0] addrReg;
    logic [DW-1:0] wdataReg;
    logic          writeReg;
    logic          grantReg;
    logic          lastGrantReg;
    logic          slvErrReg;
    logic          toPulseReg;
    logic [AW-1:0] toAddrReg;

    logic          winnerIdx;
    logic          anyReq;
    logic          loadReq;
    logic          loadResp;
    logic          timeoutHit;
    logic          cntClear;
    logic          cntEnable;
    logic          expired;

    assign anyReq    = mReq[0] | mReq[1];
    assign winnerIdx = pickWinner(mReq[0], mReq[1], lastGrantReg);

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .pCLK    (pCLK),
        .pRESETn (pRESETn),
        .clear   (cntClear),
        .enable  (cntEnable),
        .expired (expired)
    );

    // FSM state register; async reset abandons any in-flight transfer.
    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state and downstream control; pREADY is tested before the
    // watchdog so a completion on the expiry cycle is a normal one.
    always_comb begin
        stateNext  = stateReg;
        loadReq    = 1'b0;
        loadResp   = 1'b0;
        timeoutHit = 1'b0;
        cntClear   = 1'b1;
        cntEnable  = 1'b0;
        pSELx      = 1'b0;
        pENABLE    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (anyReq) begin
                    loadReq   = 1'b1;
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                pSELx     = 1'b1;
                stateNext = ACCESS;
            end
            ACCESS: begin
                pSELx     = 1'b1;
                pENABLE   = 1'b1;
                cntClear  = 1'b0;
                cntEnable = 1'b1;
                if (pREADY) begin
                    loadResp  = 1'b1;
                    stateNext = RESP;
                end else if (expired) begin
                    timeoutHit = 1'b1;
                    stateNext  = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Transfer fields, grant history, response status and watchdog report.
    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            addrReg      <= '0;
            wdataReg     <= '0;
            writeReg     <= 1'b0;
            grantReg     <= 1'b0;
            lastGrantReg <= 1'b1;
            slvErrReg    <= 1'b0;
            toPulseReg   <= 1'b0;
            toAddrReg    <= '0;
        end else begin
            toPulseReg <= timeoutHit;
            if (loadReq) begin
                addrReg      <= mAddr[winnerIdx];
                wdataReg     <= mWdata[winnerIdx];
                writeReg     <= mWrite[winnerIdx];
                grantReg     <= winnerIdx;
                lastGrantReg <= winnerIdx;
            end
            if (loadResp) begin
                slvErrReg <= pSLVERR;
            end else if (timeoutHit) begin
                slvErrReg <= 1'b1;
                toAddrReg <= addrReg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            // Read data is held per master and only the granted one updates.
            always_ff @(posedge pCLK or negedge pRESETn) begin
                if (!pRESETn) begin
                    rdataReg[gi] <= '0;
                end else if (grantReg == 1'(gi)) begin
                    if (loadResp) begin
                        rdataReg[gi] <= pRDATA;
                    end else if (timeoutHit) begin
                        rdataReg[gi] <= ERR_DATA;
                    end
                end
            end

            assign mReady[gi]  = (stateReg == RESP) && (grantReg == 1'(gi));
            assign mSlvErr[gi] = mReady[gi] && slvErrReg;
        end
    endgenerate

    assign m0_pRDATA  = rdataReg[0];
    assign m1_pRDATA  = rdataReg[1];
    assign m0_pREADY  = mReady[0];
    assign m1_pREADY  = mReady[1];
    assign m0_pSLVERR = mSlvErr[0];
    assign m1_pSLVERR = mSlvErr[1];

    assign pADDR    = addrReg;
    assign pWDATA   = wdataReg;
    assign pWRITE   = writeReg;
    assign to_pulse = toPulseReg;
    assign to_addr  = toAddrReg;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter with a scoreboard of
// expected master responses and a configurable downstream slave.
module tb_apb_master_arbiter;

    localparam int TO = 16;
    localparam logic [31:0] SALT = 32'h5A5A_5A5A;

    logic        pCLK = 1'b0;
    logic        pRESETn = 1'b0;
    logic [31:0] m0_pADDR = '0, m0_pWDATA = '0, m1_pADDR = '0, m1_pWDATA = '0;
    logic        m0_pSELx = 0, m0_pENABLE = 0, m0_pWRITE = 0;
    logic        m1_pSELx = 0, m1_pENABLE = 0, m1_pWRITE = 0;
    logic [31:0] m0_pRDATA, m1_pRDATA, pADDR, pWDATA, to_addr;
    logic        m0_pREADY, m0_pSLVERR, m1_pREADY, m1_pSLVERR;
    logic        pSELx, pENABLE, pWRITE, to_pulse;
    logic [31:0] pRDATA;
    logic        pREADY, pSLVERR;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Slave configuration and monitor observations.
    int          slvWait = 0;
    bit          slvHang = 0;
    bit          slvFixedEn = 0;
    logic [31:0] slvFixed = '0;
    bit          slvErrResp = 0;
    int          accCnt = 0;
    int          setupCyc = -1, accessCyc = -1, readyCyc = -1;
    int          b2bViol = 0, pulseCnt = 0, m0ReadyCnt = 0, m1ReadyCnt = 0, m1ReadyCyc = -1;
    bit          prevSel = 0;
    logic [64:0] obsDownQ[$];

    // Scoreboard of expected master responses, one queue per master.
    logic [31:0] expRdQ0[$], expRdQ1[$];
    bit          expErrQ0[$], expErrQ1[$];

    apb_master_arbiter #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
        .pCLK(pCLK), .pRESETn(pRESETn),
        .m0_pADDR(m0_pADDR), .m0_pWDATA(m0_pWDATA), .m0_pSELx(m0_pSELx),
        .m0_pENABLE(m0_pENABLE), .m0_pWRITE(m0_pWRITE), .m0_pRDATA(m0_pRDATA),
        .m0_pREADY(m0_pREADY), .m0_pSLVERR(m0_pSLVERR),
        .m1_pADDR(m1_pADDR), .m1_pWDATA(m1_pWDATA), .m1_pSELx(m1_pSELx),
        .m1_pENABLE(m1_pENABLE), .m1_pWRITE(m1_pWRITE), .m1_pRDATA(m1_pRDATA),
        .m1_pREADY(m1_pREADY), .m1_pSLVERR(m1_pSLVERR),
        .pADDR(pADDR), .pWDATA(pWDATA), .pSELx(pSELx), .pENABLE(pENABLE),
        .pWRITE(pWRITE), .pRDATA(pRDATA), .pREADY(pREADY), .pSLVERR(pSLVERR),
        .to_pulse(to_pulse), .to_addr(to_addr)
    );

    always #5 pCLK = ~pCLK;

    always @(posedge pCLK) cyc <= cyc + 1;

    // Downstream slave and bus monitor, sampling 1 time unit after the edge.
    initial begin
        pREADY = 0; pRDATA = '0; pSLVERR = 0;
        forever begin
            @(posedge pCLK);
            #1;
            if (pSELx && !pENABLE) begin
                setupCyc = cyc;
                if (prevSel) b2bViol++;
            end
            prevSel = pSELx;
            if (to_pulse) pulseCnt++;
            if (m0_pREADY) m0ReadyCnt++;
            if (m1_pREADY) begin m1ReadyCnt++; m1ReadyCyc = cyc; end
            if (pSELx && pENABLE) begin
                if (accCnt == 0) begin
                    accessCyc = cyc;
                    obsDownQ.push_back({pADDR, pWDATA, pWRITE});
                end
                pREADY  = !slvHang && (accCnt == slvWait);
                pRDATA  = slvFixedEn ? slvFixed : (pADDR ^ SALT);
                pSLVERR = slvErrResp;
                if (pREADY) readyCyc = cyc;
                accCnt++;
            end else begin
                pREADY = 0; pSLVERR = 0; accCnt = 0;
            end
        end
    end

    // One APB transfer from master m; expected response is queued at drive time.
    task automatic mXfer(input int m, input logic [31:0] a, input logic [31:0] w,
                         input logic wr, input logic [31:0] expRd, input bit expErr,
                         input bit keep, output int doneCyc);
        logic        rdy;
        logic [31:0] gotRd, wantRd;
        logic        gotErr, wantErr;
        logic [64:0] down;
        int          budget;
        if (m == 0) begin
            expRdQ0.push_back(expRd); expErrQ0.push_back(expErr);
            m0_pADDR = a; m0_pWDATA = w; m0_pWRITE = wr; m0_pSELx = 1; m0_pENABLE = 0;
        end else begin
            expRdQ1.push_back(expRd); expErrQ1.push_back(expErr);
            m1_pADDR = a; m1_pWDATA = w; m1_pWRITE = wr; m1_pSELx = 1; m1_pENABLE = 0;
        end
        @(posedge pCLK); #1;
        if (m == 0) m0_pENABLE = 1; else m1_pENABLE = 1;
        budget = 0; doneCyc = -1;
        rdy = (m == 0) ? m0_pREADY : m1_pREADY;
        while (!rdy && budget < 200) begin
            @(posedge pCLK); #1;
            budget++;
            rdy = (m == 0) ? m0_pREADY : m1_pREADY;
        end
        compared++;
        if (!rdy) begin
            mismatched++;
            $display("FAIL m%0d_ready_wait: pREADY never seen after %0d cycles, required within 200", m, budget);
        end else begin
            doneCyc = cyc;
            gotRd  = (m == 0) ? m0_pRDATA : m1_pRDATA;
            gotErr = (m == 0) ? m0_pSLVERR : m1_pSLVERR;
            wantRd  = (m == 0) ? expRdQ0.pop_front() : expRdQ1.pop_front();
            wantErr = (m == 0) ? expErrQ0.pop_front() : expErrQ1.pop_front();
            compared++;
            if (gotRd !== wantRd) begin
                mismatched++;
                $display("FAIL m%0d_rdata: got %h required %h", m, gotRd, wantRd);
            end
            compared++;
            if (gotErr !== wantErr) begin
                mismatched++;
                $display("FAIL m%0d_slverr: got %b required %b", m, gotErr, wantErr);
            end
            compared++;
            if (obsDownQ.size() == 0) begin
                mismatched++;
                $display("FAIL m%0d_downstream: no downstream access seen, required addr %h", m, a);
            end else begin
                down = obsDownQ.pop_front();
                if (down !== {a, w, wr}) begin
                    mismatched++;
                    $display("FAIL m%0d_downstream: got %h required %h", m, down, {a, w, wr});
                end
            end
            $display("xfer m%0d addr=%h wr=%b rdata=%h err=%b cycle=%0d", m, a, wr, gotRd, gotErr, doneCyc);
        end
        @(posedge pCLK); #1;
        if (!keep) begin
            if (m == 0) begin m0_pSELx = 0; m0_pENABLE = 0; end
            else begin m1_pSELx = 0; m1_pENABLE = 0; end
        end
    endtask

    task automatic test_reset();
        pRESETn = 0;
        repeat (3) @(posedge pCLK);
        #1;
        compared++;
        if ({pSELx, pENABLE, pWRITE, m0_pREADY, m1_pREADY, m0_pSLVERR, m1_pSLVERR, to_pulse} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {pSELx, pENABLE, pWRITE, m0_pREADY, m1_pREADY, m0_pSLVERR, m1_pSLVERR, to_pulse});
        end
        compared++;
        if ({m0_pRDATA, m1_pRDATA, to_addr, pADDR, pWDATA} !== 160'b0) begin
            mismatched++;
            $display("FAIL reset_data: m0=%h m1=%h to_addr=%h paddr=%h pwdata=%h required all 0",
                     m0_pRDATA, m1_pRDATA, to_addr, pADDR, pWDATA);
        end
        #3 pRESETn = 1;
        @(posedge pCLK); #1;
        compared++;
        if ({pSELx, pENABLE} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_idle: sel/enable got %b required 00", {pSELx, pENABLE});
        end
        $display("reset checked at cycle %0d", cyc);
    endtask

    task automatic test_contention();
        int c0, d0a, d0c, d1, r1;
        logic [31:0] aA, aB, aC;
        aA = 32'h1000_0000; aB = 32'h2000_0004; aC = 32'h1000_0008;
        r1 = m1ReadyCnt;
        c0 = cyc;
        fork
            begin
                mXfer(0, aA, 32'h0000_00AA, 1'b1, aA ^ SALT, 1'b0, 1'b1, d0a);
                mXfer(0, aC, 32'h0000_00CC, 1'b1, aC ^ SALT, 1'b0, 1'b0, d0c);
            end
            mXfer(1, aB, 32'h0000_00BB, 1'b1, aB ^ SALT, 1'b0, 1'b0, d1);
        join
        compared++;
        if (d0a - c0 !== 3) begin
            mismatched++;
            $display("FAIL contention_first_m0: m0 done at +%0d required +3", d0a - c0);
        end
        compared++;
        if (d1 - d0a !== 4) begin
            mismatched++;
            $display("FAIL contention_second_m1: m1 done %0d after m0, required 4", d1 - d0a);
        end
        compared++;
        if (d0c - d1 !== 4) begin
            mismatched++;
            $display("FAIL contention_third_m0: m0 done %0d after m1, required 4", d0c - d1);
        end
        compared++;
        if (m1ReadyCnt - r1 !== 1 || m1ReadyCyc !== d1) begin
            mismatched++;
            $display("FAIL contention_m1_ready: %0d pulses last at %0d, required 1 at %0d",
                     m1ReadyCnt - r1, m1ReadyCyc, d1);
        end
    endtask

    task automatic test_write();
        int c0, d;
        c0 = cyc;
        mXfer(0, 32'hC000_0000, 32'h0000_1234, 1'b1, 32'hC000_0000 ^ SALT, 1'b0, 1'b0, d);
        compared++;
        if (setupCyc - c0 !== 1 || accessCyc - c0 !== 2 || d - c0 !== 3) begin
            mismatched++;
            $display("FAIL write_timing: setup +%0d access +%0d ready +%0d required +1 +2 +3",
                     setupCyc - c0, accessCyc - c0, d - c0);
        end
    endtask

    task automatic test_wait_states();
        int d;
        slvWait = 5; slvFixedEn = 1; slvFixed = 32'hA5A5_A5A5;
        mXfer(1, 32'h3000_0010, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, d);
        compared++;
        if (d - readyCyc !== 1) begin
            mismatched++;
            $display("FAIL wait_latency: m1 ready %0d after slave ready, required 1", d - readyCyc);
        end
        compared++;
        if (accessCyc + 5 !== readyCyc) begin
            mismatched++;
            $display("FAIL wait_states: slave ready %0d after access, required 5", readyCyc - accessCyc);
        end
        compared++;
        if (m1_pRDATA !== 32'hA5A5_A5A5 || m0_pRDATA !== (32'hC000_0000 ^ SALT)) begin
            mismatched++;
            $display("FAIL rdata_hold: m1=%h m0=%h required %h %h",
                     m1_pRDATA, m0_pRDATA, 32'hA5A5_A5A5, 32'hC000_0000 ^ SALT);
        end
        slvWait = 0; slvFixedEn = 0;
    endtask

    task automatic test_timeout();
        int d, p0;
        p0 = pulseCnt;
        slvHang = 1;
        mXfer(0, 32'h5000_0020, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, d);
        compared++;
        if (d - setupCyc !== TO + 2) begin
            mismatched++;
            $display("FAIL timeout_latency: ready %0d after setup, required %0d", d - setupCyc, TO + 2);
        end
        compared++;
        if (pulseCnt - p0 !== 1) begin
            mismatched++;
            $display("FAIL timeout_pulse: %0d pulses, required 1", pulseCnt - p0);
        end
        compared++;
        if (to_addr !== 32'h5000_0020) begin
            mismatched++;
            $display("FAIL timeout_addr: got %h required %h", to_addr, 32'h5000_0020);
        end
        slvHang = 0;
    endtask

    task automatic test_boundary();
        int d, p0;
        p0 = pulseCnt;
        slvWait = TO; slvFixedEn = 1; slvFixed = 32'h0BAD_F00D;
        mXfer(1, 32'h6000_0000, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, d);
        compared++;
        if (pulseCnt - p0 !== 0 || d - setupCyc !== TO + 2) begin
            mismatched++;
            $display("FAIL boundary_ready: pulses %0d latency %0d, required 0 and %0d",
                     pulseCnt - p0, d - setupCyc, TO + 2);
        end
        compared++;
        if (to_addr !== 32'h5000_0020) begin
            mismatched++;
            $display("FAIL boundary_to_addr: got %h required sticky %h", to_addr, 32'h5000_0020);
        end
        slvWait = 0; slvFixedEn = 0;
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        mXfer(0, 32'h7000_0000, 32'h1111_1111, 1'b1, 32'h7000_0000 ^ SALT, 1'b0, 1'b1, d1);
        slvErrResp = 1;
        mXfer(0, 32'h7000_0004, 32'h2222_2222, 1'b0, 32'h7000_0004 ^ SALT, 1'b1, 1'b0, d2);
        slvErrResp = 0;
        compared++;
        if (d2 - d1 !== 4) begin
            mismatched++;
            $display("FAIL back_to_back: second done %0d after first, required 4", d2 - d1);
        end
        compared++;
        if (b2bViol !== 0) begin
            mismatched++;
            $display("FAIL bus_idle_gap: %0d SETUPs without idle cycle, required 0", b2bViol);
        end
    endtask

    task automatic test_async_reset();
        int c0, d, r0;
        slvHang = 1;
        m0_pADDR = 32'h8000_0000; m0_pWRITE = 1; m0_pSELx = 1; m0_pENABLE = 0;
        @(posedge pCLK); #1;
        m0_pENABLE = 1;
        repeat (4) @(posedge pCLK);
        #1;
        compared++;
        if ({pSELx, pENABLE} !== 2'b11) begin
            mismatched++;
            $display("FAIL areset_pre: sel/enable got %b required 11", {pSELx, pENABLE});
        end
        #2 pRESETn = 0;
        #1;
        compared++;
        if ({pSELx, pENABLE} !== 2'b00) begin
            mismatched++;
            $display("FAIL areset_async: sel/enable got %b required 00 before next edge", {pSELx, pENABLE});
        end
        compared++;
        if (m0_pRDATA !== 32'h0 || m1_pRDATA !== 32'h0) begin
            mismatched++;
            $display("FAIL areset_rdata: m0=%h m1=%h required 0", m0_pRDATA, m1_pRDATA);
        end
        m0_pSELx = 0; m0_pENABLE = 0;
        r0 = m0ReadyCnt;
        repeat (2) @(posedge pCLK);
        #3 pRESETn = 1;
        slvHang = 0;
        repeat (5) @(posedge pCLK);
        #1;
        compared++;
        if (m0ReadyCnt !== r0) begin
            mismatched++;
            $display("FAIL areset_no_resp: %0d m0 responses after reset, required 0", m0ReadyCnt - r0);
        end
        obsDownQ.delete();
        c0 = cyc;
        mXfer(1, 32'h9000_0000, 32'hDEAD_BEEF, 1'b1, 32'h9000_0000 ^ SALT, 1'b0, 1'b0, d);
        compared++;
        if (d - c0 !== 3) begin
            mismatched++;
            $display("FAIL areset_recover: m1 ready at +%0d required +3", d - c0);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write();
        test_wait_states();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge pCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
